// File: rtl/updn_job_arbiter.sv
// -----------------------------------------------------------------------------
// updn_job_arbiter
//   Shares one signed up/down stepping datapath between two requesters.
//   A job (start value a, signed step b, direction, step count n) is accepted
//   from one requester. Round-robin decides between requesters when both are
//   valid. The job then runs for n cycles on a W-bit accumulator. The final
//   value is returned on a valid/ready response channel, tagged with the
//   requester id.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   req{0,1}_valid/_ready    job handshake (ready is combinational, IDLE only)
//   req{0,1}_a/_b            start value / signed step
//   req{0,1}_dir             1 = add b each step, 0 = subtract b
//   req{0,1}_n               number of steps
//   rsp_valid/_ready         result handshake
//   rsp_id, rsp_q            owner id and final accumulator value
//   busy                     high while a job is running or its result waits
//   q_live                   current accumulator value (debug)
// -----------------------------------------------------------------------------
module updn_job_arbiter #(
  parameter int W  = 8,
  parameter int NW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [W-1:0]  req0_a,
  input  logic [W-1:0]  req0_b,
  input  logic          req0_dir,
  input  logic [NW-1:0] req0_n,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [W-1:0]  req1_a,
  input  logic [W-1:0]  req1_b,
  input  logic          req1_dir,
  input  logic [NW-1:0] req1_n,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [W-1:0]  rsp_q,
  output logic          busy,
  output logic [W-1:0]  q_live
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [NW-1:0] REM_ONE  = {{(NW-1){1'b0}}, 1'b1};
  localparam logic [NW-1:0] REM_ZERO = {NW{1'b0}};

  state_t        state_q, state_d;
  logic [W-1:0]  acc_q,   acc_d;
  logic [W-1:0]  b_q,     b_d;
  logic [NW-1:0] rem_q,   rem_d;
  logic          dir_q,   dir_d;
  logic          id_q,    id_d;
  logic          rr_q,    rr_d;   // 0 favours req0 on a tie, 1 favours req1

  logic          sel1_s;          // requester 1 is the granted one
  logic          accept_s;        // a handshake completes this cycle
  logic [W-1:0]  a_sel_s;
  logic [W-1:0]  b_sel_s;
  logic          dir_sel_s;
  logic [NW-1:0] n_sel_s;

  // Grant selection and job-field mux. A lone valid requester wins
  // regardless of the pointer, so nobody idles waiting for its turn.
  always_comb begin
    sel1_s     = req1_valid & (~req0_valid | rr_q);
    accept_s   = (state_q == S_IDLE) & (req0_valid | req1_valid);
    req0_ready = (state_q == S_IDLE) & req0_valid & ~sel1_s;
    req1_ready = (state_q == S_IDLE) & sel1_s;
    if (sel1_s) begin
      a_sel_s   = req1_a;
      b_sel_s   = req1_b;
      dir_sel_s = req1_dir;
      n_sel_s   = req1_n;
    end else begin
      a_sel_s   = req0_a;
      b_sel_s   = req0_b;
      dir_sel_s = req0_dir;
      n_sel_s   = req0_n;
    end
  end

  // Next-state and datapath update for the IDLE -> RUN -> DONE job sequence.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    id_d    = id_q;
    rr_d    = rr_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          acc_d   = a_sel_s;
          b_d     = b_sel_s;
          dir_d   = dir_sel_s;
          rem_d   = n_sel_s;
          id_d    = sel1_s;
          // A zero-step job goes straight to DONE with acc equal to a.
          if (n_sel_s == REM_ZERO) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Modulo-2**W arithmetic. b is two's complement, so the plain add and
        // subtract already give signed behaviour.
        if (dir_q) begin
          acc_d = acc_q + b_q;
        end else begin
          acc_d = acc_q - b_q;
        end
        rem_d = rem_q - REM_ONE;
        if (rem_q == REM_ONE) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rr_d    = ~id_q;   // favour the requester not just served
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset discards any job in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      rem_q   <= {NW{1'b0}};
      dir_q   <= 1'b0;
      id_q    <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
    end
  end

  // Response and status outputs come straight from the registers.
  always_comb begin
    rsp_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    rsp_id    = id_q;
    rsp_q     = acc_q;
    q_live    = acc_q;
  end

endmodule

// File: tb/tb_updn_job_arbiter.sv
module tb_updn_job_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a = 8'd0, req0_b = 8'd0, req1_a = 8'd0, req1_b = 8'd0;
  logic       req0_dir = 1'b0, req1_dir = 1'b0;
  logic [5:0] req0_n = 6'd0, req1_n = 6'd0;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_id, busy;
  logic [7:0] rsp_q, q_live;

  int checks = 0;
  int errors = 0;

  updn_job_arbiter #(.W(8), .NW(6)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_dir(req0_dir), .req0_n(req0_n),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_dir(req1_dir), .req1_n(req1_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_q(rsp_q), .busy(busy), .q_live(q_live)
  );

  always #5 clk = ~clk;

  // Present a job on requester r at a negedge, wait (bounded) for ready,
  // let the accept edge pass, drop valid. Returns at the negedge after E0.
  task automatic submit(input bit r, input logic [7:0] a, input logic [7:0] b,
                        input bit dir, input logic [5:0] n, output bit ok);
    ok = 1'b0;
    if (r) begin
      req1_a = a; req1_b = b; req1_dir = dir; req1_n = n; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_dir = dir; req0_n = n; req0_valid = 1'b1;
    end
    #1;
    for (int i = 0; i < 10; i++) begin
      if ((r ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Count edges from E0 until rsp_valid is seen (bounded).
  task automatic wait_rsp(output int cnt);
    cnt = 0;
    while (rsp_valid !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  // Take the response: one cycle of rsp_ready, back at a negedge in IDLE.
  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({rsp_valid, rsp_id, rsp_q, busy, q_live, req0_ready, req1_ready} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {rsp_valid, rsp_id, rsp_q, busy, q_live, req0_ready, req1_ready});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_up();
    bit ok; int cnt;
    submit(1'b0, 8'd53, 8'd13, 1'b1, 6'd3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL t1_ready: got 0 want 1"); end
    checks++;
    if (req0_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL t1_ready_drop: ready=%b busy=%b want 0 1", req0_ready, busy);
    end
    wait_rsp(cnt);
    checks++;
    if (cnt != 3) begin errors++; $display("FAIL t1_latency: got %0d want 3", cnt); end
    checks++;
    if (rsp_q !== 8'h5C || rsp_id !== 1'b0) begin
      errors++; $display("FAIL t1_result: got q=%h id=%b want 5c 0", rsp_q, rsp_id);
    end
    consume();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL t1_idle: got valid=%b busy=%b want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_down_live();
    bit ok;
    submit(1'b1, 8'hEF, 8'd37, 1'b0, 6'd2, ok);
    checks++;
    if (!ok || q_live !== 8'hEF) begin
      errors++; $display("FAIL t2_accept: got ok=%b q_live=%h want 1 ef", ok, q_live);
    end
    @(negedge clk);
    checks++;
    if (q_live !== 8'hCA || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL t2_live1: got %h valid=%b want ca 0", q_live, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (q_live !== 8'hA5 || rsp_valid !== 1'b1 || rsp_q !== 8'hA5 || rsp_id !== 1'b1) begin
      errors++; $display("FAIL t2_result: got q=%h v=%b id=%b want a5 1 1", rsp_q, rsp_valid, rsp_id);
    end
    consume();
  endtask

  // Both requesters valid; returns id of the one granted first and its result.
  task automatic race(output bit first, output logic [7:0] q1, output logic [7:0] q2,
                      output bit id2);
    int cnt;
    req0_a = 8'd29;  req0_b = 8'hEF; req0_dir = 1'b1; req0_n = 6'd4; req0_valid = 1'b1;
    req1_a = 8'hD1;  req1_b = 8'hD5; req1_dir = 1'b0; req1_n = 6'd3; req1_valid = 1'b1;
    #1;
    first = req1_ready;
    @(posedge clk);
    @(negedge clk);
    if (first) req1_valid = 1'b0; else req0_valid = 1'b0;
    wait_rsp(cnt);
    q1 = rsp_q;
    consume();
    // The other requester stays valid and is taken in this IDLE cycle.
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(cnt);
    q2  = rsp_q;
    id2 = rsp_id;
    consume();
  endtask

  task automatic test_round_robin();
    bit first, id2; logic [7:0] q1, q2;
    race(first, q1, q2, id2);
    checks++;
    if (first !== 1'b0 || q1 !== 8'hD9) begin
      errors++; $display("FAIL t3_first: got id=%b q=%h want 0 d9", first, q1);
    end
    checks++;
    if (id2 !== 1'b1 || q2 !== 8'h52) begin
      errors++; $display("FAIL t3_second: got id=%b q=%h want 1 52", id2, q2);
    end
    // Last served was req1, so req0 is favoured again.
    race(first, q1, q2, id2);
    checks++;
    if (first !== 1'b0 || id2 !== 1'b1) begin
      errors++; $display("FAIL t3_repeat: got first=%b second=%b want 0 1", first, id2);
    end
    // Serve req0 alone; the next tie must go to req1.
    begin
      bit ok; int cnt;
      submit(1'b0, 8'd1, 8'd1, 1'b1, 6'd1, ok);
      wait_rsp(cnt);
      consume();
    end
    race(first, q1, q2, id2);
    checks++;
    if (first !== 1'b1 || q1 !== 8'h52 || q2 !== 8'hD9) begin
      errors++; $display("FAIL t3_alternate: got first=%b q1=%h q2=%h want 1 52 d9", first, q1, q2);
    end
  endtask

  task automatic test_wrap_zero();
    bit ok; int cnt;
    submit(1'b1, 8'd120, 8'd10, 1'b1, 6'd1, ok);
    wait_rsp(cnt);
    checks++;
    if (cnt != 1 || rsp_q !== 8'h82) begin
      errors++; $display("FAIL t4_wrap: got cnt=%0d q=%h want 1 82", cnt, rsp_q);
    end
    consume();
    submit(1'b0, 8'd5, 8'd7, 1'b1, 6'd0, ok);
    checks++;
    if (!ok || rsp_valid !== 1'b1 || rsp_q !== 8'd5 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL t4_zero: got ok=%b v=%b q=%h id=%b want 1 1 05 0",
                         ok, rsp_valid, rsp_q, rsp_id);
    end
    consume();
  endtask

  task automatic test_backpressure();
    bit ok; int cnt; int bad = 0;
    submit(1'b1, 8'd10, 8'd3, 1'b0, 6'd2, ok);
    wait_rsp(cnt);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rsp_valid !== 1'b1 || rsp_q !== 8'd4 || rsp_id !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL t5_hold: got %0d bad cycles want 0 (q=%h)", bad, rsp_q);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    consume();
  endtask

  task automatic test_async_reset();
    bit ok; int seen = 0;
    submit(1'b0, 8'd50, 8'd2, 1'b1, 6'd20, ok);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_q, busy, q_live, req0_ready, req1_ready} !== 20'd0) begin
      errors++; $display("FAIL t6_async: got %h want 0",
                         {rsp_valid, rsp_id, rsp_q, busy, q_live, req0_ready, req1_ready});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL t6_no_rsp: got %0d want 0", seen); end
    begin
      int cnt;
      submit(1'b1, 8'd100, 8'd30, 1'b1, 6'd2, ok);
      wait_rsp(cnt);
      checks++;
      if (cnt != 2 || rsp_q !== 8'hA0 || rsp_id !== 1'b1) begin
        errors++; $display("FAIL t6_fresh: got cnt=%0d q=%h id=%b want 2 a0 1", cnt, rsp_q, rsp_id);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    // Reset put the pointer back on req0; req1 was served since, so it stays req0.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL t6_tie: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_up();
    test_down_live();
    test_round_robin();
    test_wrap_zero();
    test_backpressure();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
